// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the scan-chain wrapper: FSM states,
// scan-chain field offsets, S-box, xtime and round constants.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Operand word layout
  localparam int SCAN_W        = 387;
  localparam int PT_MSB        = 386;
  localparam int PT_LSB        = 259;
  localparam int KEY_FIELD_MSB = 258;
  localparam int KEY_MSB       = 130;
  localparam int KEY_LSB       = 3;
  localparam int PT_SEL_BIT    = 2;
  localparam int KEY_SEL_BIT   = 1;
  localparam int CT_SEL_BIT    = 0;

  // Result word: upper bits above ciphertext and plaintext are zero
  localparam int OUT_PAD_W     = SCAN_W - 256;

  // FIPS-197 S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TBL[8 * (255 - int'(b)) +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for rounds 1..10
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_scan_if_if.sv
// Scan-chain operand/result bundle between the capture host and the AES core.
interface aes_scan_if_if;
  import aes_pkg::*;

  logic [SCAN_W-1:0] SCAN_CHAIN;
  logic              ENABLE;
  logic              TRIGGER_EXT;
  logic [SCAN_W-1:0] CIPHERTEXT;
  logic [127:0]      CT_OUT;

  modport master (
    output SCAN_CHAIN,
    output ENABLE,
    input  TRIGGER_EXT,
    input  CIPHERTEXT,
    input  CT_OUT
  );

  modport slave (
    input  SCAN_CHAIN,
    input  ENABLE,
    output TRIGGER_EXT,
    output CIPHERTEXT,
    output CT_OUT
  );

endinterface

// File: rtl/aes_round.sv
// One combinational AES-128 round plus on-the-fly key expansion.
// The new round key is derived from the current one and applied in
// the same round; final_rnd skips MixColumns for round 10.
module aes_round (
  input  logic [127:0] state_in,
  input  logic [127:0] rkey_in,
  input  logic [7:0]   rcon_in,
  input  logic         final_rnd,
  output logic [127:0] state_out,
  output logic [127:0] rkey_out
);
  import aes_pkg::*;

  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [7:0]  mc [16];
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] kt;
  logic [31:0] n0, n1, n2, n3;

  // Byte i sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state_in[8*(15-i) +: 8]);
  end

  // Row r rotates left by r columns
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Key schedule: RotWord, SubWord and rcon on the last word
  assign w0 = rkey_in[127:96];
  assign w1 = rkey_in[95:64];
  assign w2 = rkey_in[63:32];
  assign w3 = rkey_in[31:0];
  assign kt = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
            ^ {rcon_in, 24'h000000};
  assign n0 = w0 ^ kt;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rkey_out = {n0, n1, n2, n3};

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign state_out[8*(15-i) +: 8] = (final_rnd ? sr[i] : mc[i]) ^ rkey_out[8*(15-i) +: 8];
  end

endmodule

// File: rtl/aes_scan_if.sv
// Scan-chain AES-128 wrapper for side-channel capture. A rising edge of
// ENABLE in IDLE latches the operands and runs ten rounds, one per clock.
// TRIGGER_EXT pulses for one cycle at start and again at completion.
//
// state | meaning
// IDLE  | waiting for an ENABLE rising edge
// RUN   | applying rounds 1..10, one per clock
// DONE  | result published, one-cycle recovery before IDLE
module aes_scan_if (
  input  logic        CLK,
  input  logic        RST_N,
  aes_scan_if_if.slave bus
);
  import aes_pkg::*;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]   st;
  logic         enable_q;
  logic         trig_q;
  logic [3:0]   rnd_q;
  logic         start;
  logic         last_rnd;

  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic [127:0] key_q;
  logic [127:0] pt_q;
  logic         ct_sel_q;

  // prev_ct_q doubles as the published ciphertext field
  logic [127:0] prev_ct_q;
  logic [127:0] out_pt_q;
  logic [127:0] ct_out_q;

  logic [127:0] pt_mux;
  logic [127:0] key_mux;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic [7:0]   rnd_rcon;
  logic         unused_key_hi;

  assign start    = (st == IDLE) && bus.ENABLE && !enable_q;
  assign last_rnd = (rnd_q == 4'd10);
  assign rnd_rcon = rcon(rnd_q);

  assign pt_mux  = bus.SCAN_CHAIN[PT_SEL_BIT]  ? bus.SCAN_CHAIN[PT_MSB:PT_LSB]   : prev_ct_q;
  assign key_mux = bus.SCAN_CHAIN[KEY_SEL_BIT] ? bus.SCAN_CHAIN[KEY_MSB:KEY_LSB] : key_q;

  // Only the low half of the 256-bit key field is an AES-128 key
  assign unused_key_hi = ^bus.SCAN_CHAIN[KEY_FIELD_MSB:KEY_MSB+1];

  aes_round u_round (
    .state_in  (state_q),
    .rkey_in   (rk_q),
    .rcon_in   (rnd_rcon),
    .final_rnd (last_rnd),
    .state_out (rnd_state),
    .rkey_out  (rnd_key)
  );

  // Registered copy of ENABLE for rising-edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) enable_q <= 1'b0;
    else        enable_q <= bus.ENABLE;
  end

  // Sequencer: state, round counter and the two trigger pulses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st     <= IDLE;
      trig_q <= 1'b0;
      rnd_q  <= 4'd0;
    end else begin
      case (st)
        IDLE: begin
          trig_q <= start;
          if (start) begin
            st    <= RUN;
            rnd_q <= 4'd1;
          end
        end
        RUN: begin
          rnd_q <= rnd_q + 4'd1;
          if (last_rnd) begin
            st     <= DONE;
            trig_q <= 1'b1;
          end else begin
            trig_q <= 1'b0;
          end
        end
        DONE: begin
          trig_q <= 1'b0;
          st     <= IDLE;
        end
        default: begin
          trig_q <= 1'b0;
          st     <= IDLE;
        end
      endcase
    end
  end

  // Operand latch with initial AddRoundKey, then one round per RUN cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= '0;
      rk_q     <= '0;
      key_q    <= '0;
      pt_q     <= '0;
      ct_sel_q <= 1'b0;
    end else if (start) begin
      state_q  <= pt_mux ^ key_mux;
      rk_q     <= key_mux;
      key_q    <= key_mux;
      pt_q     <= pt_mux;
      ct_sel_q <= bus.SCAN_CHAIN[CT_SEL_BIT];
    end else if (st == RUN) begin
      state_q <= rnd_state;
      rk_q    <= rnd_key;
    end
  end

  // Result registers, updated only when round 10 completes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_ct_q <= '0;
      out_pt_q  <= '0;
      ct_out_q  <= '0;
    end else if ((st == RUN) && last_rnd) begin
      prev_ct_q <= rnd_state;
      out_pt_q  <= pt_q;
      ct_out_q  <= ct_sel_q ? rnd_state : '0;
    end
  end

  assign bus.TRIGGER_EXT = trig_q;
  assign bus.CIPHERTEXT  = {{OUT_PAD_W{1'b0}}, out_pt_q, prev_ct_q};
  assign bus.CT_OUT      = ct_out_q;

endmodule

// File: tb/tb_aes_scan_if.sv
// Self-checking bench for aes_scan_if: known-answer vectors, chaining,
// trigger timing, ENABLE edge handling, mid-run reset and random operands
// against a table-driven AES-128 reference.
module tb_aes_scan_if;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  aes_scan_if_if bus ();

  aes_scan_if dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic [127:0] m_prev_ct;
  logic [127:0] m_key;
  logic [386:0] m_ct_out;
  logic [127:0] m_ct128;

  int   trig_rises = 0;
  logic trig_d     = 1'b0;

  always @(negedge CLK) begin
    if (bus.TRIGGER_EXT && !trig_d) trig_rises <= trig_rises + 1;
    trig_d <= bus.TRIGGER_EXT;
  end

  task automatic chk_eq(input string tag, input logic [386:0] got, input logic [386:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
        if (r < 10) begin
          for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
              s[4*c+row] = gmul(8'h02, t[4*c+row]) ^ gmul(8'h03, t[4*c+(row+1)%4])
                         ^ t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
        end else begin
          for (int i = 0; i < 16; i++) s[i] = t[i];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4*c+row] = s[4*c+row] ^ w[4*r+c][31-8*row -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_outputs(input string tag);
    chk_eq({tag, "_ct"}, bus.CIPHERTEXT, m_ct_out);
    chk_eq({tag, "_ctout"}, {259'b0, bus.CT_OUT}, {259'b0, m_ct128});
  endtask

  // One encryption with cycle-by-cycle trigger checks from E0 to E11
  task automatic do_enc(input string tag, input bit ps, input bit ks, input bit cs,
                        input logic [127:0] pt, input logic [127:0] key,
                        input bit use_known, input logic [127:0] known,
                        input bit toggle_en, input bit hold_en);
    logic [127:0] pt_used;
    logic [127:0] ct;
    int r0;
    @(negedge CLK);
    bus.ENABLE     = 1'b0;
    bus.SCAN_CHAIN = {pt, rand128(), key, ps, ks, cs};
    @(negedge CLK);
    bus.ENABLE = 1'b1;
    r0 = trig_rises;
    pt_used = ps ? pt : m_prev_ct;
    if (ks) m_key = key;
    ct = aes_ref(pt_used, m_key);
    @(negedge CLK);
    chk_eq({tag, "_trig_e0"}, {386'b0, bus.TRIGGER_EXT}, 387'd1);
    chk_eq({tag, "_hold_e0"}, bus.CIPHERTEXT, m_ct_out);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      chk_eq($sformatf("%s_trig_e%0d", tag, k), {386'b0, bus.TRIGGER_EXT}, 387'd0);
      if (toggle_en) bus.ENABLE = (k < 9) ? ((k % 2) == 0) : 1'b1;
    end
    @(negedge CLK);
    m_prev_ct = ct;
    m_ct_out  = {131'b0, pt_used, ct};
    m_ct128   = cs ? ct : 128'h0;
    chk_eq({tag, "_trig_e10"}, {386'b0, bus.TRIGGER_EXT}, 387'd1);
    chk_outputs({tag, "_e10"});
    if (use_known) chk_eq({tag, "_kat"}, {259'b0, bus.CIPHERTEXT[127:0]}, {259'b0, known});
    @(negedge CLK);
    chk_eq({tag, "_trig_e11"}, {386'b0, bus.TRIGGER_EXT}, 387'd0);
    if (!hold_en) bus.ENABLE = 1'b0;
    repeat (14) @(negedge CLK);
    chk_eq({tag, "_pulses"}, 387'(trig_rises - r0), 387'd2);
    chk_outputs({tag, "_hold"});
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] CH_CT  = 128'hf795bd4a52e29ed713d313fa20e98dbc;

  initial begin
    int r0;
    build_sbox();
    m_prev_ct = '0; m_key = '0; m_ct_out = '0; m_ct128 = '0;
    RST_N = 1'b0;
    bus.ENABLE = 1'b0;
    bus.SCAN_CHAIN = '0;
    repeat (3) @(negedge CLK);
    chk_eq("rst_trig", {386'b0, bus.TRIGGER_EXT}, 387'd0);
    chk_outputs("rst");
    RST_N = 1'b1;

    do_enc("c1", 1, 1, 1, C1_PT, C1_KEY, 1, C1_CT, 0, 0);
    do_enc("b_sel1", 1, 1, 1, B_PT, B_KEY, 1, B_CT, 0, 0);
    do_enc("b_sel0", 1, 1, 0, B_PT, B_KEY, 1, B_CT, 0, 0);
    do_enc("zero", 1, 1, 1, 128'h0, 128'h0, 1, Z_CT, 0, 1);
    do_enc("chain", 0, 0, 1, rand128(), rand128(), 1, CH_CT, 0, 0);
    do_enc("toggle", 1, 1, 1, rand128(), rand128(), 0, 128'h0, 1, 0);
    for (int n = 0; n < 6; n++)
      do_enc($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), rand128(), rand128(), 0, 128'h0, 0, 0);

    // Reset at E5 of a running encryption
    @(negedge CLK);
    bus.ENABLE     = 1'b0;
    bus.SCAN_CHAIN = {C1_PT, 128'h0, C1_KEY, 3'b111};
    @(negedge CLK);
    bus.ENABLE = 1'b1;
    repeat (6) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    m_prev_ct = '0; m_key = '0; m_ct_out = '0; m_ct128 = '0;
    chk_eq("midrst_trig", {386'b0, bus.TRIGGER_EXT}, 387'd0);
    chk_outputs("midrst");
    bus.ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    r0 = trig_rises;
    repeat (12) @(negedge CLK);
    chk_eq("postrst_quiet", 387'(trig_rises - r0), 387'd0);
    chk_outputs("postrst");
    do_enc("postrst_zero", 0, 0, 1, rand128(), rand128(), 1, Z_CT, 0, 0);
    do_enc("postrst_c1", 1, 1, 1, C1_PT, C1_KEY, 1, C1_CT, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
